// File: rtl/tx_fcs_inserter.sv
// Passes PSDU bytes to the scrambler and feeds each byte to the external CRC32
// engine as two nibbles. After the last byte it appends the 4-byte FCS.
module tx_fcs_inserter #(
  parameter int LEN_WIDTH = 12,
  parameter int MAX_LEN   = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 crc_rst,
  output logic                 crc_en,
  output logic [3:0]           crc_nibble,
  input  logic [31:0]          crc_in,
  output logic [LEN_WIDTH-1:0] psdu_len,
  output logic                 len_err,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, FCS} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;
  localparam int unsigned          MAX_U   = MAX_LEN;

  state_t      state;
  logic [3:0]  hi_nibble;
  logic        last_reg;
  logic [31:0] fcs_reg;
  logic [2:0]  fcs_cnt;
  logic [7:0]  fcs_byte;
  logic        out_fire;
  logic        out_free;
  logic        accept;

  assign out_fire = out_valid & out_ready;
  assign out_free = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign crc_rst  = accept & (state == IDLE);
  assign busy     = (state != IDLE);

  // A byte may only be taken when the output register is free by the next edge.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    in_ready = 1'b1;
        LO:      in_ready = ~last_reg & out_free;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (fcs_cnt[1:0])
      2'd0:    fcs_byte = fcs_reg[7:0];
      2'd1:    fcs_byte = fcs_reg[15:8];
      2'd2:    fcs_byte = fcs_reg[23:16];
      default: fcs_byte = fcs_reg[31:24];
    endcase
  end

  // crc_en/crc_nibble are registered, so the nibble of a byte accepted in one
  // cycle reaches the engine during the next (HI) and the one after (LO/WAIT).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      crc_en     <= 1'b0;
      crc_nibble <= '0;
      hi_nibble  <= '0;
      last_reg   <= 1'b0;
      fcs_reg    <= '0;
      fcs_cnt    <= '0;
    end else begin
      crc_en <= 1'b0;
      if (out_fire) out_valid <= 1'b0;
      case (state)
        IDLE, LO: begin
          if (accept) begin
            hi_nibble  <= in_data[7:4];
            last_reg   <= in_last;
            out_data   <= in_data;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            crc_en     <= 1'b1;
            crc_nibble <= in_data[3:0];
            state      <= HI;
          end else if (state == LO && last_reg) begin
            state <= WAIT;
          end
        end
        HI: begin
          crc_en     <= 1'b1;
          crc_nibble <= hi_nibble;
          state      <= LO;
        end
        WAIT: begin
          fcs_reg <= crc_in;
          fcs_cnt <= '0;
          state   <= FCS;
        end
        FCS: begin
          if (out_fire && out_last) begin
            out_last <= 1'b0;
            state    <= IDLE;
          end else if (out_free && !fcs_cnt[2]) begin
            out_data  <= fcs_byte;
            out_valid <= 1'b1;
            out_last  <= (fcs_cnt == 3'd3);
            fcs_cnt   <= fcs_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Length counts every emitted byte; oversize is flagged but never truncated.
  always_ff @(posedge clk) begin
    if (rst) begin
      psdu_len <= '0;
      len_err  <= 1'b0;
    end else if (crc_rst) begin
      psdu_len <= '0;
      len_err  <= 1'b0;
    end else if (out_fire) begin
      if (psdu_len != LEN_SAT) psdu_len <= psdu_len + 1'b1;
      if (32'(psdu_len) >= MAX_U) len_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_fcs_inserter.sv
// Randomised self-checking bench for tx_fcs_inserter with a behavioural CRC32
// engine stub and a byte-level FCS reference model.
module tb_tx_fcs_inserter;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [3:0] nib_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        crc_rst;
  logic        crc_en;
  logic [3:0]  crc_nibble;
  logic [31:0] crc_in;
  logic [11:0] psdu_len;
  logic        len_err;
  logic        busy;

  logic        s_in_ready, s_out_valid, s_out_last, s_crc_rst, s_crc_en, s_len_err, s_busy;
  logic [7:0]  s_out_data;
  logic [3:0]  s_crc_nibble;
  logic [3:0]  s_psdu_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_fcs_inserter dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .crc_rst(crc_rst), .crc_en(crc_en), .crc_nibble(crc_nibble),
    .crc_in(crc_in), .psdu_len(psdu_len), .len_err(len_err), .busy(busy)
  );

  // Same stimulus, small length limits: exercises len_err and saturation.
  tx_fcs_inserter #(.LEN_WIDTH(4), .MAX_LEN(8)) dut_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid), .out_last(s_out_last),
    .out_ready(out_ready), .crc_rst(s_crc_rst), .crc_en(s_crc_en), .crc_nibble(s_crc_nibble),
    .crc_in(crc_in), .psdu_len(s_psdu_len), .len_err(s_len_err), .busy(s_busy)
  );

  // Nibble-serial CRC32 engine stand-in (reflected, LSB first).
  logic [31:0] crc_state;
  assign crc_in = ~crc_state;
  always @(posedge clk) begin
    if (rst || crc_rst) crc_state <= 32'hFFFF_FFFF;
    else if (crc_en) begin
      logic [31:0] c;
      c = crc_state ^ {28'd0, crc_nibble};
      for (int k = 0; k < 4; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_state <= c;
    end
  end

  function automatic logic [31:0] ref_crc(input byte_q_t b);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t p);
    byte_q_t q = p;
    logic [31:0] c = ref_crc(p);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    q.push_back(c[23:16]);
    q.push_back(c[31:24]);
    return q;
  endfunction

  // out_ready pattern: 0 = always, 1 = toggle, 2 = random.
  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: collects the output/nibble streams and tracks the handshake count
  // of the current frame to check psdu_len, len_err and output stability.
  bit          mon_en = 0;
  int          cyc = 0;
  int          m_hs = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  byte_q_t     out_q;
  nib_q_t      nib_q;
  int          crst_cnt = 0;
  int          frames_done = 0;
  int          start_q[$];
  int          end_q[$];

  always @(negedge clk) begin
    int e_big, e_small;
    cyc++;
    if (mon_en) begin
      checks++;
      if (crc_rst && crc_en) begin
        errors++;
        $display("[TB] FAIL crc_rst_with_en got rst=%0b en=%0b expected not both", crc_rst, crc_en);
      end
      if (!rst) begin
        e_big   = (m_hs > 4095) ? 4095 : m_hs;
        e_small = (m_hs > 15) ? 15 : m_hs;
        checks += 4;
        if (psdu_len !== 12'(e_big)) begin
          errors++;
          $display("[TB] FAIL psdu_len got %0d expected %0d", psdu_len, e_big);
        end
        if (s_psdu_len !== 4'(e_small)) begin
          errors++;
          $display("[TB] FAIL small_psdu_len got %0d expected %0d", s_psdu_len, e_small);
        end
        if (len_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL len_err got %0b expected 0", len_err);
        end
        if (s_len_err !== (m_hs > 8)) begin
          errors++;
          $display("[TB] FAIL small_len_err got %0b expected %0b (count %0d)", s_len_err, (m_hs > 8), m_hs);
        end
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== prev_data) begin
            errors++;
            $display("[TB] FAIL hold_under_stall got v=%0b d=%02h expected v=1 d=%02h", out_valid, out_data, prev_data);
          end
        end
        if (out_valid && out_ready) begin
          out_q.push_back(out_data);
          if (out_last) begin
            frames_done++;
            end_q.push_back(cyc);
          end
        end
        if (crc_en) nib_q.push_back(crc_nibble);
        if (crc_rst) begin
          crst_cnt++;
          start_q.push_back(cyc);
        end
      end
      if (rst || crc_rst) m_hs = 0;
      else if (out_valid && out_ready) m_hs++;
      prev_stall = out_valid & ~out_ready & ~rst;
      prev_data  = out_data;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    nib_q.delete();
    start_q.delete();
    end_q.delete();
    crst_cnt = 0;
    frames_done = 0;
  endtask

  task automatic drive_frame(input byte_q_t p);
    int i = 0;
    int guard = 0;
    @(posedge clk);
    #2;
    while (i < p.size()) begin
      in_valid = 1'b1;
      in_data  = p[i];
      in_last  = (i == p.size() - 1);
      @(negedge clk);
      if (in_ready) i++;
      @(posedge clk);
      #2;
      guard++;
      if (guard > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL drive_timeout got %0d bytes accepted expected %0d", i, p.size());
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int guard = 0;
    while (frames_done < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (frames_done < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout got %0d frames expected %0d", frames_done, n);
    end
    @(negedge clk);
  endtask

  function automatic byte_q_t digits();
    byte_q_t p;
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    mon_en = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 10;
    if (in_ready !== 1'b0)    begin errors++; $display("[TB] FAIL reset_in_ready got %0b expected 0", in_ready); end
    if (out_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_out_valid got %0b expected 0", out_valid); end
    if (out_last !== 1'b0)    begin errors++; $display("[TB] FAIL reset_out_last got %0b expected 0", out_last); end
    if (crc_rst !== 1'b0)     begin errors++; $display("[TB] FAIL reset_crc_rst got %0b expected 0", crc_rst); end
    if (crc_en !== 1'b0)      begin errors++; $display("[TB] FAIL reset_crc_en got %0b expected 0", crc_en); end
    if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
    if (len_err !== 1'b0)     begin errors++; $display("[TB] FAIL reset_len_err got %0b expected 0", len_err); end
    if (out_data !== 8'h00)   begin errors++; $display("[TB] FAIL reset_out_data got %02h expected 00", out_data); end
    if (crc_nibble !== 4'h0)  begin errors++; $display("[TB] FAIL reset_crc_nibble got %0h expected 0", crc_nibble); end
    if (psdu_len !== 12'd0)   begin errors++; $display("[TB] FAIL reset_psdu_len got %0d expected 0", psdu_len); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready got %0b expected 1", in_ready); end
  endtask

  task automatic test_known_vector();
    byte_q_t exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                     8'h26, 8'h39, 8'hF4, 8'hCB};
    clear_mon();
    rdy_mode = 0;
    drive_frame(digits());
    wait_frames(1);
    checks += 4;
    if (out_q.size() !== exp.size()) begin errors++; $display("[TB] FAIL known_size got %0d expected %0d", out_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL known_byte%0d got %02h expected %02h", i, out_q[i], exp[i]); end
    end
    if (psdu_len !== 12'd13) begin errors++; $display("[TB] FAIL known_psdu_len got %0d expected 13", psdu_len); end
    if (s_len_err !== 1'b1)  begin errors++; $display("[TB] FAIL known_small_len_err got %0b expected 1", s_len_err); end
    if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL known_busy got %0b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    byte_q_t p = digits();
    byte_q_t exp = with_fcs(p);
    nib_q_t  en;
    foreach (p[i]) begin
      en.push_back(p[i][3:0]);
      en.push_back(p[i][7:4]);
    end
    clear_mon();
    rdy_mode = 1;
    drive_frame(p);
    wait_frames(1);
    rdy_mode = 0;
    checks += 3;
    if (out_q.size() !== exp.size()) begin errors++; $display("[TB] FAIL bp_size got %0d expected %0d", out_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL bp_byte%0d got %02h expected %02h", i, out_q[i], exp[i]); end
    end
    if (nib_q.size() !== 18) begin errors++; $display("[TB] FAIL bp_nibble_count got %0d expected 18", nib_q.size()); end
    else foreach (en[i]) begin
      checks++;
      if (nib_q[i] !== en[i]) begin errors++; $display("[TB] FAIL bp_nibble%0d got %0h expected %0h", i, nib_q[i], en[i]); end
    end
    if (crst_cnt !== 1) begin errors++; $display("[TB] FAIL bp_crc_rst_count got %0d expected 1", crst_cnt); end
  endtask

  task automatic test_single_byte();
    byte_q_t p = '{8'h00};
    byte_q_t exp = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    clear_mon();
    rdy_mode = 0;
    drive_frame(p);
    wait_frames(1);
    checks += 2;
    if (out_q.size() !== exp.size()) begin errors++; $display("[TB] FAIL single_size got %0d expected %0d", out_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL single_byte%0d got %02h expected %02h", i, out_q[i], exp[i]); end
    end
    if (psdu_len !== 12'd5) begin errors++; $display("[TB] FAIL single_psdu_len got %0d expected 5", psdu_len); end
  endtask

  task automatic test_back_to_back();
    byte_q_t exp = with_fcs(digits());
    clear_mon();
    rdy_mode = 0;
    drive_frame(digits());
    drive_frame(digits());
    wait_frames(2);
    checks += 3;
    if (out_q.size() !== 26) begin errors++; $display("[TB] FAIL b2b_size got %0d expected 26", out_q.size()); end
    else for (int i = 0; i < 26; i++) begin
      checks++;
      if (out_q[i] !== exp[i % 13]) begin errors++; $display("[TB] FAIL b2b_byte%0d got %02h expected %02h", i, out_q[i], exp[i % 13]); end
    end
    if (crst_cnt !== 2) begin errors++; $display("[TB] FAIL b2b_crc_rst_count got %0d expected 2", crst_cnt); end
    if (start_q.size() !== 2 || end_q.size() !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_events got %0d/%0d expected 2/2", start_q.size(), end_q.size());
    end else if (start_q[1] - end_q[0] !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_gap got %0d expected 1", start_q[1] - end_q[0]);
    end
  endtask

  task automatic test_random();
    byte_q_t exp;
    nib_q_t  en;
    int nframes = 6;
    clear_mon();
    for (int f = 0; f < nframes; f++) begin
      byte_q_t p;
      int len = (f == 0) ? 14 : $urandom_range(1, 14);
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      foreach (p[i]) begin
        en.push_back(p[i][3:0]);
        en.push_back(p[i][7:4]);
      end
      exp = {exp, with_fcs(p)};
      rdy_mode = $urandom_range(0, 2);
      drive_frame(p);
      wait_frames(f + 1);
      checks++;
      if (psdu_len !== 12'(len + 4)) begin errors++; $display("[TB] FAIL rand_psdu_len got %0d expected %0d", psdu_len, len + 4); end
    end
    rdy_mode = 0;
    checks += 3;
    if (out_q.size() !== exp.size()) begin errors++; $display("[TB] FAIL rand_size got %0d expected %0d", out_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL rand_byte%0d got %02h expected %02h", i, out_q[i], exp[i]); end
    end
    if (nib_q.size() !== en.size()) begin errors++; $display("[TB] FAIL rand_nibble_count got %0d expected %0d", nib_q.size(), en.size()); end
    else foreach (en[i]) begin
      checks++;
      if (nib_q[i] !== en[i]) begin errors++; $display("[TB] FAIL rand_nibble%0d got %0h expected %0h", i, nib_q[i], en[i]); end
    end
    if (crst_cnt !== nframes) begin errors++; $display("[TB] FAIL rand_crc_rst_count got %0d expected %0d", crst_cnt, nframes); end
  endtask

  task automatic test_reset_mid_fcs();
    byte_q_t exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                     8'h26, 8'h39, 8'hF4, 8'hCB};
    int guard = 0;
    clear_mon();
    rdy_mode = 0;
    drive_frame(digits());
    while (m_hs < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m_hs < 10) begin errors++; $display("[TB] FAIL rst_fcs_reach got %0d handshakes expected 10", m_hs); end
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %0b expected 0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy got %0b expected 0", busy); end
    if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL rst_in_ready got %0b expected 1", in_ready); end
    if (psdu_len !== 12'd0) begin errors++; $display("[TB] FAIL rst_psdu_len got %0d expected 0", psdu_len); end
    clear_mon();
    drive_frame(digits());
    wait_frames(1);
    checks += 2;
    if (out_q.size() !== exp.size()) begin errors++; $display("[TB] FAIL rst_new_size got %0d expected %0d", out_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin errors++; $display("[TB] FAIL rst_new_byte%0d got %02h expected %02h", i, out_q[i], exp[i]); end
    end
    if (psdu_len !== 12'd13) begin errors++; $display("[TB] FAIL rst_new_psdu_len got %0d expected 13", psdu_len); end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_single_byte();
    test_back_to_back();
    test_random();
    test_reset_mid_fcs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fcs_inserter.md
Name: tx_fcs_inserter

Overview:
- Sits between the TX MAC-to-PHY byte stream and the scrambler/encoder stage of the OFDM transmitter.
- Passes each PSDU byte through unchanged and drives the external nibble-serial CRC32 engine.
- After the last payload byte, appends the 4-byte FCS.
- Reports the total frame length and flags oversize frames.

Parameters:
- LEN_WIDTH, 12, width of the byte counter and psdu_len output.
- MAX_LEN, 4095, maximum total frame length (payload plus FCS) in bytes. A larger frame raises len_err.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_data  input  8  payload byte
- in_valid  input  1  in_data valid
- in_last  input  1  marks the final payload byte; qualified by in_valid
- in_ready  output  1  block can accept a byte this cycle
- out_data  output  8  payload or FCS byte
- out_valid  output  1  out_data valid
- out_last  output  1  marks the final FCS byte
- out_ready  input  1  downstream accepts out_data
- crc_rst  output  1  one-cycle clear pulse to the CRC engine
- crc_en  output  1  CRC engine nibble enable
- crc_nibble  output  4  nibble to the CRC engine
- crc_in  input  32  CRC engine output; equals the final FCS bit pattern, no inversion needed
- psdu_len  output  LEN_WIDTH  bytes emitted in the current or last frame, FCS included
- len_err  output  1  sticky until the next frame start; frame exceeded MAX_LEN
- busy  output  1  frame in progress (state other than IDLE)

Behaviour:
- Reset: state IDLE. These outputs are 0: in_ready, out_valid, out_last, crc_rst, crc_en, busy, len_err, out_data, crc_nibble, psdu_len.
- States: IDLE, LO, HI, WAIT, FCS.
- IDLE:
  - in_ready = 1.
  - On accept of the first byte: pulse crc_rst and clear psdu_len/len_err in the same cycle, then proceed as in LO.
- Byte accept (in_valid & in_ready) in IDLE or LO:
  - Latch the byte and in_last.
  - Load out_data and set out_valid on the next edge, so out_data appears 1 cycle after accept.
  - Go to HI.
- Nibble feed:
  - Cycle after accept (HI): crc_en = 1, crc_nibble = byte[3:0].
  - Following cycle: crc_en = 1, crc_nibble = byte[7:4].
  - Low nibble is always first; crc_rst never coincides with crc_en.
- in_ready:
  - Low in HI, WAIT and FCS.
  - In LO it is high only when the output register is empty, or is being drained this cycle (out_valid & out_ready).
  - Peak throughput is one byte per 2 cycles.
- Backpressure:
  - out_data/out_valid hold while out_ready = 0.
  - Nibble feeding is never stalled; the CRC engine never waits on downstream.
- Last byte: after its high-nibble cycle, go to WAIT for one cycle so crc_in updates.
- FCS capture: on entering FCS, snapshot crc_in into fcs_reg.
- FCS output:
  - Emit fcs_reg[7:0], [15:8], [23:16], [31:24] in that order.
  - Each byte advances only on out_valid & out_ready.
  - out_last = 1 with the 4th byte.
  - No crc_en during FCS.
- Frame end: after the 4th FCS byte is accepted, return to IDLE. A new frame may be accepted in the following cycle.
- psdu_len:
  - Increments on every out handshake, saturating at all-ones.
  - Holds its final value until the next frame start.
- len_err: set when an out handshake would make the count exceed MAX_LEN. The frame is still completed (no truncation).
- Zero-length frame: impossible; the first accepted byte always starts a frame.
- Accept while out_valid pending: allowed only when that byte drains in the same cycle; otherwise in_ready = 0.
- in_last on the first byte: valid, gives a 1-byte payload plus 4 FCS bytes = 5 bytes.
- Reset mid-frame:
  - Returns to IDLE and clears all outputs the next cycle.
  - Any partially sent FCS is abandoned.
  - crc_rst is not pulsed by rst itself; the engine shares rst.

Test Plan:
- Payload "123456789" (0x31..0x39), out_ready = 1 → out stream 31..39, 26, 39, F4, CB. out_last on CB. psdu_len = 13, len_err = 0.
- Same payload with out_ready toggling 1-0-1 each cycle → identical byte sequence. crc_en pulses exactly 18, with nibble order 1,3,2,3,...,9,3.
- 1-byte payload 0x00 → FCS bytes 8D, EF, 02, D2 (CRC32 = 0xD202EF8D). psdu_len = 5.
- Back-to-back frames "123456789" then "123456789" → both end with 26, 39, F4, CB. crc_rst pulses once per frame. No idle gap beyond 1 cycle.
- MAX_LEN = 8 with a 9-byte payload → len_err rises on the 9th handshake. All 13 bytes still emitted. len_err clears at the next frame start.
- rst asserted during the 2nd FCS byte → next cycle out_valid = 0, busy = 0, in_ready = 1. A new "123456789" frame then produces the correct FCS 26, 39, F4, CB.
